// File: rtl/muldiv_pkg.sv
// Definitions shared by the multiply/divide sequencers of the multicycle MIPS datapath.
package muldiv_pkg;

   localparam int MULDIV_WIDTH   = 32;
   localparam int MULDIV_TIMEOUT = 64;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_ARM,
      S_WAIT,
      S_COMMIT
   } hilo_state_t;

endpackage

// File: rtl/hilo_unit_if.sv
// Handshake and data bundle between the HI/LO sequencer and the multicycle multiplier.
interface hilo_unit_if
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MULDIV_WIDTH
);
   logic [WIDTH-1:0] mult_x;
   logic [WIDTH-1:0] mult_y;
   logic             mult_control;
   logic             mult_operando;
   logic [WIDTH-1:0] mult_hi;
   logic [WIDTH-1:0] mult_lo;

   modport master (
      output mult_x, mult_y, mult_control,
      input  mult_operando, mult_hi, mult_lo
   );

   modport slave (
      input  mult_x, mult_y, mult_control,
      output mult_operando, mult_hi, mult_lo
   );
endinterface

// File: rtl/hilo_regs.sv
// Architectural HI/LO pair; a product commit takes priority over MTHI/MTLO writes.
module hilo_regs
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MULDIV_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             commit,
   input  logic [WIDTH-1:0] prod_hi,
   input  logic [WIDTH-1:0] prod_lo,
   input  logic             wr_en,
   input  logic             mthi_we,
   input  logic             mtlo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   always_ff @(posedge clk) begin
      if (!reset) begin
         hi <= '0;
         lo <= '0;
      end else if (commit) begin
         hi <= prod_hi;
         lo <= prod_lo;
      end else if (wr_en) begin
         if (mthi_we) hi <= wdata;
         if (mtlo_we) lo <= wdata;
      end
   end

endmodule

// File: rtl/hilo_unit.sv
// MULT sequencer: latches operands, launches the multiplier, tracks its busy flag,
// commits the product into HI/LO and aborts through a watchdog if the multiplier stalls.
module hilo_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH   = MULDIV_WIDTH,
   parameter int TIMEOUT = MULDIV_TIMEOUT,
   parameter int CNT_W   = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mult_req,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             mthi_we,
   input  logic             mtlo_we,
   input  logic [WIDTH-1:0] wdata,
   hilo_unit_if.master      mif,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             timeout_err
);

   hilo_state_t      state;
   logic [CNT_W-1:0] wd_cnt;
   logic [CNT_W-1:0] wd_next;
   logic             wd_expired;
   logic             commit;

   assign wd_next    = wd_cnt + CNT_W'(1);
   assign wd_expired = (wd_next >= CNT_W'(TIMEOUT));
   assign commit     = (state == S_COMMIT);

   // Operands stay latched after the launch so the multiplier sees them constant throughout.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state            <= S_IDLE;
         wd_cnt           <= '0;
         mif.mult_x       <= '0;
         mif.mult_y       <= '0;
         mif.mult_control <= 1'b0;
         busy             <= 1'b0;
         done             <= 1'b0;
         timeout_err      <= 1'b0;
      end else begin
         done             <= 1'b0;
         mif.mult_control <= 1'b0;
         case (state)
            S_IDLE: begin
               if (mult_req) begin
                  mif.mult_x       <= rs_val;
                  mif.mult_y       <= rt_val;
                  mif.mult_control <= 1'b1;
                  busy             <= 1'b1;
                  state            <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               wd_cnt <= '0;
               state  <= S_ARM;
            end
            S_ARM: begin
               wd_cnt <= wd_next;
               if (mif.mult_operando) begin
                  state <= S_WAIT;
               end else if (wd_expired) begin
                  busy        <= 1'b0;
                  timeout_err <= 1'b1;
                  state       <= S_IDLE;
               end
            end
            S_WAIT: begin
               wd_cnt <= wd_next;
               if (!mif.mult_operando) begin
                  state <= S_COMMIT;
               end else if (wd_expired) begin
                  busy        <= 1'b0;
                  timeout_err <= 1'b1;
                  state       <= S_IDLE;
               end
            end
            S_COMMIT: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   hilo_regs #(.WIDTH(WIDTH)) u_regs (
      .clk     (clk),
      .reset   (reset),
      .commit  (commit),
      .prod_hi (mif.mult_hi),
      .prod_lo (mif.mult_lo),
      .wr_en   (!busy),
      .mthi_we (mthi_we),
      .mtlo_we (mtlo_we),
      .wdata   (wdata),
      .hi      (hi),
      .lo      (lo)
   );

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit with a behavioural multiplier stub on the slave side.
module tb_hilo_unit;
   import muldiv_pkg::*;

   localparam int W = 32;

   logic         clk      = 1'b0;
   logic         reset    = 1'b0;
   logic         mult_req = 1'b0;
   logic         mthi_we  = 1'b0;
   logic         mtlo_we  = 1'b0;
   logic [W-1:0] rs_val   = '0;
   logic [W-1:0] rt_val   = '0;
   logic [W-1:0] wdata    = '0;
   logic [W-1:0] hi, lo;
   logic         busy, done, timeout_err;

   hilo_unit_if #(.WIDTH(W)) mif ();

   hilo_unit #(.WIDTH(W), .TIMEOUT(64), .CNT_W(7)) dut (
      .clk         (clk),
      .reset       (reset),
      .mult_req    (mult_req),
      .rs_val      (rs_val),
      .rt_val      (rt_val),
      .mthi_we     (mthi_we),
      .mtlo_we     (mtlo_we),
      .wdata       (wdata),
      .mif         (mif),
      .hi          (hi),
      .lo          (lo),
      .busy        (busy),
      .done        (done),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   // Multiplier stub: raises operando for stub_k cycles after each start strobe.
   logic               stub_live = 1'b1;
   int                 stub_k    = 4;
   int                 stub_left = 0;
   int                 n_launch  = 0;
   logic               stub_op   = 1'b0;
   logic [W-1:0]       stub_hi   = '0;
   logic [W-1:0]       stub_lo   = '0;
   logic signed [63:0] stub_prod;

   assign stub_prod         = $signed(mif.mult_x) * $signed(mif.mult_y);
   assign mif.mult_operando = stub_op;
   assign mif.mult_hi       = stub_hi;
   assign mif.mult_lo       = stub_lo;

   always @(posedge clk) begin
      if (mif.mult_control) begin
         n_launch <= n_launch + 1;
         if (stub_live) begin
            stub_hi   <= stub_prod[63:32];
            stub_lo   <= stub_prod[31:0];
            stub_op   <= 1'b1;
            stub_left <= stub_k;
         end
      end else if (stub_left > 0) begin
         if (stub_left == 1) stub_op <= 1'b0;
         stub_left <= stub_left - 1;
      end
   end

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_vec  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_done: hi=%h lo=%h with nothing pending", hi, lo);
         end else begin
            mon_e = sb.pop_front();
            check("commit_hi", 64'(hi), 64'(mon_e.hi));
            check("commit_lo", 64'(lo), 64'(mon_e.lo));
            check("busy_at_done", 64'(busy), 64'(0));
         end
      end
   end

   task automatic wait_done(input string name, input int budget, output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!done && cycles < budget);
      if (!done) begin
         n_vec++;
         n_fail++;
         $display("FAIL %s: no done within %0d cycles", name, budget);
      end
   endtask

   task automatic mult_op(input logic [W-1:0] x, input logic [W-1:0] y, input int k);
      stub_k   = k;
      rs_val   = x;
      rt_val   = y;
      mult_req = 1'b1;
      @(negedge clk);
      mult_req = 1'b0;
   endtask

   int cyc;
   int base_launch;

   initial begin
      repeat (3) @(negedge clk);
      check("rst_hi", 64'(hi), 64'(0));
      check("rst_lo", 64'(lo), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_timeout", 64'(timeout_err), 64'(0));
      check("rst_ctrl", 64'(mif.mult_control), 64'(0));
      check("rst_x", 64'(mif.mult_x), 64'(0));
      reset = 1'b1;
      @(negedge clk);

      // 1000000 x 7, with latency and single-launch checks
      base_launch = n_launch;
      sb.push_back('{hi: 32'h0, lo: 32'd7000000});
      mult_op(32'd1000000, 32'd7, 4);
      check("busy_after_req", 64'(busy), 64'(1));
      check("ctrl_in_launch", 64'(mif.mult_control), 64'(1));
      wait_done("mul_7", 50, cyc);
      check("latency_k4", 64'(cyc + 1), 64'(8));
      @(negedge clk);
      check("done_one_cycle", 64'(done), 64'(0));
      check("launch_count_1", 64'(n_launch - base_launch), 64'(1));

      // 1000000 x -4
      sb.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFC2F700});
      mult_op(32'd1000000, 32'hFFFFFFFC, 3);
      wait_done("mul_neg4", 50, cyc);
      @(negedge clk);

      // MTHI while idle
      wdata   = 32'hDEADBEEF;
      mthi_we = 1'b1;
      @(negedge clk);
      mthi_we = 1'b0;
      check("mthi_hi", 64'(hi), 64'(32'hDEADBEEF));
      check("mthi_lo_kept", 64'(lo), 64'(32'hFFC2F700));

      // MTLO while busy is dropped; commit then writes the product
      sb.push_back('{hi: 32'h0, lo: 32'd30});
      mult_op(32'd5, 32'd6, 4);
      wdata   = 32'h1234;
      mtlo_we = 1'b1;
      @(negedge clk);
      mtlo_we = 1'b0;
      check("mtlo_busy_dropped", 64'(lo), 64'(32'hFFC2F700));
      wait_done("mul_5x6", 50, cyc);
      @(negedge clk);

      // Watchdog: the multiplier never answers
      stub_live   = 1'b0;
      base_launch = n_launch;
      mult_op(32'd7, 32'd7, 4);
      cyc = 0;
      while (!timeout_err && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("timeout_latency", 64'(cyc + 1), 64'(66));
      check("timeout_err_set", 64'(timeout_err), 64'(1));
      check("timeout_busy", 64'(busy), 64'(0));
      check("timeout_hi_kept", 64'(hi), 64'(0));
      check("timeout_lo_kept", 64'(lo), 64'(30));
      check("timeout_one_launch", 64'(n_launch - base_launch), 64'(1));
      stub_live = 1'b1;
      sb.push_back('{hi: 32'h0, lo: 32'd6});
      mult_op(32'd2, 32'd3, 2);
      wait_done("after_timeout", 50, cyc);
      check("timeout_sticky", 64'(timeout_err), 64'(1));
      @(negedge clk);

      // Reset in WAIT discards the operation; the stale operando fall must not commit
      mult_op(32'd9, 32'd9, 10);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("midrst_busy", 64'(busy), 64'(0));
      check("midrst_hi", 64'(hi), 64'(0));
      check("midrst_lo", 64'(lo), 64'(0));
      check("midrst_timeout", 64'(timeout_err), 64'(0));
      reset = 1'b1;
      repeat (15) @(negedge clk);
      check("midrst_busy_later", 64'(busy), 64'(0));
      check("midrst_lo_later", 64'(lo), 64'(0));

      // mult_req held high: one launch per IDLE visit, back-to-back products
      base_launch = n_launch;
      stub_k = 3;
      sb.push_back('{hi: 32'h0, lo: 32'd3003000});
      sb.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFF0B9D8});
      rs_val   = 32'd1001000;
      rt_val   = 32'd3;
      mult_req = 1'b1;
      wait_done("b2b_first", 50, cyc);
      rt_val = 32'hFFFFFFFF;
      wait_done("b2b_second", 50, cyc);
      mult_req = 1'b0;
      repeat (3) @(negedge clk);
      check("b2b_launches", 64'(n_launch - base_launch), 64'(2));
      check("b2b_idle", 64'(busy), 64'(0));

      check("scoreboard_empty", 64'(sb.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Downstream and sequencing partner of the multicycle multiplier (`mult`) in the multicycle MIPS datapath.
- Accepts a MULT request from the control unit and latches the operands.
- Drives `mult_control` to launch the multiplier and tracks its `operando` busy flag.
- Commits the multiplier's hi/lo result into architectural HI/LO registers; also serves MTHI/MTLO writes and provides a busy/stall signal plus a timeout watchdog.

Parameters:
- WIDTH, 32: data width of operands, HI and LO.
- TIMEOUT, 64: maximum cycles from launch to operando falling before an abort.
- CNT_W, 7: width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- mult_req  in  1  control unit requests MULT; sampled only in IDLE.
- rs_val  in  WIDTH  operand A.
- rt_val  in  WIDTH  operand B.
- mthi_we  in  1  write wdata into HI.
- mtlo_we  in  1  write wdata into LO.
- wdata  in  WIDTH  MTHI/MTLO data.
- mult_x  out  WIDTH  latched operand A to the multiplier.
- mult_y  out  WIDTH  latched operand B to the multiplier.
- mult_control  out  1  multiplier start strobe.
- mult_operando  in  1  multiplier busy flag.
- mult_hi  in  WIDTH  multiplier upper product.
- mult_lo  in  WIDTH  multiplier lower product.
- hi  out  WIDTH  architectural HI.
- lo  out  WIDTH  architectural LO.
- busy  out  1  high while an operation is in flight; the control unit stalls MFHI/MFLO/MULT on it.
- done  out  1  one-cycle pulse when a product is committed.
- timeout_err  out  1  sticky abort flag.

Behaviour:
- Reset (reset==0 at an edge): registers cleared.
  - State goes to IDLE.
  - hi, lo, mult_x, mult_y and the counter go to 0.
  - mult_control, busy, done and timeout_err go to 0.
  - Reset overrides everything, including mid-operation: any in-flight result is discarded.
- FSM states: IDLE, LAUNCH, ARM, WAIT, COMMIT.
  - IDLE, mult_req=1 at an edge: latch mult_x<=rs_val and mult_y<=rt_val, go to LAUNCH.
  - LAUNCH: mult_control=1 for exactly this one cycle; counter<=0; go to ARM.
  - ARM: wait for mult_operando==1, then go to WAIT.
  - WAIT: wait for mult_operando==0, then go to COMMIT.
  - COMMIT: at the edge, hi<=mult_hi, lo<=mult_lo and done<=1 (registered, high exactly one cycle, coincident with the new hi/lo). Then go to IDLE.
- busy: registered, high in LAUNCH, ARM, WAIT and COMMIT.
  - Asserted the cycle after mult_req is accepted.
  - Deasserted the cycle done is high.
- mult_x/mult_y: held stable from LAUNCH until the next accepted request, so the multiplier always sees constant operands.
- Watchdog: counter increments every cycle in ARM and WAIT.
  - When it reaches TIMEOUT: go to IDLE, set timeout_err=1 (sticky until reset), hi/lo unchanged, no done pulse.
- MTHI/MTLO:
  - Honoured only when busy==0; hi<=wdata on mthi_we, lo<=wdata on mtlo_we, both allowed in the same cycle.
  - Writes while busy==1 are dropped.
  - Same cycle as an accepted mult_req: the write takes effect, and the later commit overwrites it.
- mult_req while busy: ignored; no queueing.
- Arithmetic: the block performs no arithmetic; the product is signed 64-bit as produced by `mult`, split hi/lo.
- Latency: commit edge = request edge + 3 + K cycles, where K is the number of cycles operando stays high.

Decomposition:
- Shared package `muldiv_pkg`:
  - the FSM state enum `hilo_state_t`;
  - localparams for WIDTH and default TIMEOUT;
  - the same package is to be reused by a later div sequencer.
- One natural sub-module: `hilo_regs`, the HI/LO register pair with its write-priority logic (commit > MTHI/MTLO).
- The FSM and watchdog stay in `hilo_unit`.

Test Plan:
- MULT 1000000 x 7, using the real `mult` instance → one mult_control pulse; hi=0, lo=7000000; done high for 1 cycle; busy low the same cycle.
- MULT 1000000 x (-4) → hi=32'hFFFFFFFF, lo=32'hFFC2F700.
- Stub multiplier that never raises operando, TIMEOUT=64 → timeout_err=1 after 64 ARM/WAIT cycles; hi/lo keep their prior values; no done; a new mult_req is then accepted.
- MTHI 32'hDEADBEEF while idle → hi updates next cycle. MTLO 32'h1234 asserted while busy → lo unchanged after commit except for the product.
- Reset driven low during WAIT → next cycle busy=0, hi=lo=0; a stale operando fall afterwards causes no commit.
- mult_req held high across a whole operation → exactly one launch per IDLE visit; back-to-back products 1001000x3 then 1001000x(-1) commit lo=3003000 then lo=32'hFFF0B9D8 with hi=32'hFFFFFFFF.
